// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the queued writeback entry type for the register-file writer.
package wb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int REG_COUNT = 32;
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO of writeback entries, exposing per-slot valid and rd for hazard masks.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         valid,
    output logic [ADDR_W-1:0]        rd [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    wb_entry_t mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    assign dout  = mem[rptr];
    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] off;
        assign off      = PW'(i) - rptr;
        assign valid[i] = {1'b0, off} < count;
        assign rd[i]    = mem[i].rd;
    end
endmodule

// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter: register-file writer arbitrating ALU writeback over queued mul/div results.
// Define WB_FWD_EN to add the write-port forwarding outputs FWD_HIT1/2 and FWD_DATA1/2.
module reg_writeback_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ALU_VALID,
    input  logic [ADDR_W-1:0]             ALU_RD,
    input  logic [DATA_W-1:0]             ALU_DATA,
    input  logic                          MD_VALID,
    output logic                          MD_READY,
    input  logic [ADDR_W-1:0]             MD_RD,
    input  logic [DATA_W-1:0]             MD_DATA,
    output logic                          PIPE_STALL,
    output logic [wb_pkg::REG_COUNT-1:0]  PENDING,
    output logic                          WRITEENABLE,
    output logic [ADDR_W-1:0]             WRITEADDRESS,
    output logic [DATA_W-1:0]             WRITEDATA
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]             FWD_RS1,
    input  logic [ADDR_W-1:0]             FWD_RS2,
    output logic                          FWD_HIT1,
    output logic                          FWD_HIT2,
    output logic [DATA_W-1:0]             FWD_DATA1,
    output logic [DATA_W-1:0]             FWD_DATA2
`endif
);
    import wb_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    wb_entry_t din, head;
    logic full, empty, alu_req, push, pop;
    logic [CW-1:0] count, count_next;
    logic [DEPTH-1:0] valid;
    logic [wb_pkg::ADDR_W-1:0] rd_arr [DEPTH];
    assign alu_req    = ALU_VALID && ALU_RD != '0;
    assign pop        = !alu_req && !empty;
    assign MD_READY   = !RESET && !full;
    // Results aimed at r0 complete the handshake but never occupy a slot.
    assign push       = MD_VALID && MD_READY && MD_RD != '0;
    assign count_next = count + CW'(push) - CW'(pop);
    assign din        = '{rd: MD_RD, data: MD_DATA};
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count),
        .valid (valid),
        .rd    (rd_arr)
    );
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WRITEENABLE  <= 1'b0;
            WRITEADDRESS <= '0;
            WRITEDATA    <= '0;
            PIPE_STALL   <= 1'b0;
        end else begin
            WRITEENABLE  <= alu_req || pop;
            WRITEADDRESS <= alu_req ? ALU_RD : pop ? head.rd : WRITEADDRESS;
            WRITEDATA    <= alu_req ? ALU_DATA : pop ? head.data : WRITEDATA;
            PIPE_STALL   <= count_next >= CW'(DEPTH - 1);
        end
    end
    always_comb begin
        PENDING = '0;
        for (int i = 0; i < DEPTH; i++) if (valid[i]) PENDING[rd_arr[i]] = 1'b1;
        PENDING[0] = 1'b0;
    end
`ifdef WB_FWD_EN
    assign FWD_HIT1  = WRITEENABLE && WRITEADDRESS == FWD_RS1 && FWD_RS1 != '0;
    assign FWD_HIT2  = WRITEENABLE && WRITEADDRESS == FWD_RS2 && FWD_RS2 != '0;
    assign FWD_DATA1 = FWD_HIT1 ? WRITEDATA : '0;
    assign FWD_DATA2 = FWD_HIT2 ? WRITEDATA : '0;
`endif
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// tb_reg_writeback_arbiter: randomized and directed bench against a queue-based writeback model.
module tb_reg_writeback_arbiter;
    localparam int DEPTH = 4, DW = 32, AW = 5;
    logic CLK = 0, RESET = 0, ALU_VALID = 0, MD_VALID = 0;
    logic [AW-1:0] ALU_RD = 0, MD_RD = 0;
    logic [DW-1:0] ALU_DATA = 0, MD_DATA = 0;
    logic MD_READY, PIPE_STALL, WRITEENABLE;
    logic [31:0] PENDING;
    logic [AW-1:0] WRITEADDRESS;
    logic [DW-1:0] WRITEDATA;
`ifdef WB_FWD_EN
    logic [AW-1:0] FWD_RS1 = 0, FWD_RS2 = 0;
    logic FWD_HIT1, FWD_HIT2;
    logic [DW-1:0] FWD_DATA1, FWD_DATA2;
`endif
    int n_chk = 0, n_fail = 0;
    typedef struct {logic [AW-1:0] rd; logic [DW-1:0] data;} ent_t;
    ent_t q[$];
    logic m_we = 0, m_stall = 0;
    logic [AW-1:0] m_addr = 0;
    logic [DW-1:0] m_data = 0;
    logic pre_ready, exp_ready;
    logic [31:0] pre_pend, exp_pend;

    always #5 CLK = ~CLK;

    reg_writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
        .MD_VALID(MD_VALID), .MD_READY(MD_READY), .MD_RD(MD_RD), .MD_DATA(MD_DATA),
        .PIPE_STALL(PIPE_STALL), .PENDING(PENDING), .WRITEENABLE(WRITEENABLE),
        .WRITEADDRESS(WRITEADDRESS), .WRITEDATA(WRITEDATA)
`ifdef WB_FWD_EN
        , .FWD_RS1(FWD_RS1), .FWD_RS2(FWD_RS2), .FWD_HIT1(FWD_HIT1), .FWD_HIT2(FWD_HIT2),
        .FWD_DATA1(FWD_DATA1), .FWD_DATA2(FWD_DATA2)
`endif
    );

    function automatic logic [31:0] pend_of();
        logic [31:0] p = '0;
        foreach (q[i]) p[q[i].rd] = 1'b1;
        return p;
    endfunction

    // One clock: drive inputs, sample combinational outputs mid-cycle, advance model past the edge.
    task automatic tick(input logic r, input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                        input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
        ent_t e;
        RESET = r; ALU_VALID = av; ALU_RD = ar; ALU_DATA = ad; MD_VALID = mv; MD_RD = mr; MD_DATA = md;
        exp_ready = !r && q.size() < DEPTH;
        exp_pend  = pend_of();
        #1;
        pre_ready = MD_READY;
        pre_pend  = PENDING;
        @(posedge CLK);
        #1;
        if (r) begin
            q.delete();
            {m_we, m_addr, m_data, m_stall} = '0;
        end else begin
            if (av && ar != 0) begin
                m_we = 1; m_addr = ar; m_data = ad;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_we = 1; m_addr = e.rd; m_data = e.data;
            end else m_we = 0;
            if (mv && exp_ready && mr != 0) q.push_back('{mr, md});
            m_stall = q.size() >= DEPTH - 1;
        end
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (pre_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got=%b want=0", pre_ready); end
        n_chk++;
        if ({WRITEENABLE, WRITEADDRESS, WRITEDATA, PIPE_STALL} !== '0) begin
            n_fail++; $display("FAIL reset_regs got we=%b a=%0d d=%h st=%b want all 0", WRITEENABLE, WRITEADDRESS, WRITEDATA, PIPE_STALL);
        end
        idle();
        n_chk++;
        if (pre_ready !== 1'b1 || pre_pend !== 32'h0) begin
            n_fail++; $display("FAIL reset_idle got ready=%b pend=%h want ready=1 pend=0", pre_ready, pre_pend);
        end
        n_chk++;
        if (WRITEENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_idle_we got=%b want=0", WRITEENABLE); end
    endtask

    task automatic test_alu();
        tick(0, 1, 5, 32'hA5A5A5A5, 0, 0, 0);
        n_chk++;
        if ({WRITEENABLE, WRITEADDRESS, WRITEDATA} !== {1'b1, 5'd5, 32'hA5A5A5A5}) begin
            n_fail++; $display("FAIL alu_write got we=%b a=%0d d=%h want 1/5/a5a5a5a5", WRITEENABLE, WRITEADDRESS, WRITEDATA);
        end
        tick(0, 1, 0, 32'h11111111, 0, 0, 0);
        n_chk++;
        if ({WRITEENABLE, WRITEADDRESS, WRITEDATA} !== {1'b0, 5'd5, 32'hA5A5A5A5}) begin
            n_fail++; $display("FAIL alu_r0 got we=%b a=%0d d=%h want 0/5/a5a5a5a5", WRITEENABLE, WRITEADDRESS, WRITEDATA);
        end
    endtask

    task automatic test_md();
        tick(0, 0, 0, 0, 1, 7, 32'h12345678);
        n_chk++;
        if (pre_ready !== 1'b1 || WRITEENABLE !== 1'b0) begin
            n_fail++; $display("FAIL md_accept got ready=%b we=%b want ready=1 we=0", pre_ready, WRITEENABLE);
        end
        idle();
        n_chk++;
        if (pre_pend !== 32'h80) begin n_fail++; $display("FAIL md_pending got=%h want=00000080", pre_pend); end
        n_chk++;
        if ({WRITEENABLE, WRITEADDRESS, WRITEDATA} !== {1'b1, 5'd7, 32'h12345678}) begin
            n_fail++; $display("FAIL md_write got we=%b a=%0d d=%h want 1/7/12345678", WRITEENABLE, WRITEADDRESS, WRITEDATA);
        end
        idle();
        n_chk++;
        if (pre_pend !== 32'h0 || WRITEENABLE !== 1'b0) begin
            n_fail++; $display("FAIL md_clear got pend=%h we=%b want 0/0", pre_pend, WRITEENABLE);
        end
        tick(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
        idle();
        n_chk++;
        if (pre_pend !== 32'h0 || WRITEENABLE !== 1'b0) begin
            n_fail++; $display("FAIL md_r0_discard got pend=%h we=%b want 0/0", pre_pend, WRITEENABLE);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom);
            n_chk++;
            if (pre_ready !== (i < 4) || pre_ready !== exp_ready || pre_pend !== exp_pend) begin
                n_fail++; $display("FAIL b2b_ready cyc=%0d got ready=%b pend=%h want ready=%b pend=%h", i, pre_ready, pre_pend, exp_ready, exp_pend);
            end
            n_chk++;
            if (PIPE_STALL !== (i >= 2) || {WRITEENABLE, WRITEADDRESS, WRITEDATA} !== {m_we, m_addr, m_data}) begin
                n_fail++; $display("FAIL b2b_wb cyc=%0d got we=%b a=%0d d=%h st=%b want %b/%0d/%h/%b", i, WRITEENABLE, WRITEADDRESS, WRITEDATA, PIPE_STALL, m_we, m_addr, m_data, i >= 2);
            end
        end
        for (int i = 0; i < 6; i++) begin
            idle();
            n_chk++;
            if ({pre_ready, pre_pend, WRITEENABLE, WRITEADDRESS, WRITEDATA, PIPE_STALL} !== {exp_ready, exp_pend, m_we, m_addr, m_data, m_stall}) begin
                n_fail++; $display("FAIL drain cyc=%0d got rdy=%b pend=%h we=%b a=%0d d=%h st=%b want %b/%h/%b/%0d/%h/%b", i, pre_ready, pre_pend, WRITEENABLE, WRITEADDRESS, WRITEDATA, PIPE_STALL, exp_ready, exp_pend, m_we, m_addr, m_data, m_stall);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(0, 1, 3, 32'h1, 1, 9, 32'h99);
        tick(0, 1, 4, 32'h2, 1, 10, 32'hAA);
        tick(1, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (WRITEENABLE !== 1'b0 || PIPE_STALL !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_we got we=%b st=%b want 0/0", WRITEENABLE, PIPE_STALL);
        end
        idle();
        n_chk++;
        if (pre_pend !== 32'h0 || pre_ready !== 1'b1 || WRITEENABLE !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_after got pend=%h ready=%b we=%b want 0/1/0", pre_pend, pre_ready, WRITEENABLE);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 60) == 0, $urandom % 2, 5'($urandom % 4 == 0 ? 0 : $urandom), $urandom,
                 ($urandom % 10) < 6, 5'($urandom % 8 == 0 ? 0 : $urandom), $urandom);
            n_chk++;
            if ({pre_ready, WRITEENABLE, WRITEADDRESS, WRITEDATA, PIPE_STALL} !== {exp_ready, m_we, m_addr, m_data, m_stall}
                || (!RESET && i > 0 && pre_pend !== exp_pend)) begin
                n_fail++; $display("FAIL random cyc=%0d got rdy=%b pend=%h we=%b a=%0d d=%h st=%b want %b/%h/%b/%0d/%h/%b", i, pre_ready, pre_pend, WRITEENABLE, WRITEADDRESS, WRITEDATA, PIPE_STALL, exp_ready, exp_pend, m_we, m_addr, m_data, m_stall);
            end
        end
    endtask

`ifdef WB_FWD_EN
    task automatic test_fwd();
        tick(0, 1, 3, 32'hDEADBEEF, 0, 0, 0);
        FWD_RS1 = 3; FWD_RS2 = 0;
        #1;
        n_chk++;
        if ({FWD_HIT1, FWD_DATA1, FWD_HIT2, FWD_DATA2} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL fwd got h1=%b d1=%h h2=%b d2=%h want 1/deadbeef/0/0", FWD_HIT1, FWD_DATA1, FWD_HIT2, FWD_DATA2);
        end
        FWD_RS1 = 4; FWD_RS2 = 3;
        #1;
        n_chk++;
        if ({FWD_HIT1, FWD_DATA1, FWD_HIT2, FWD_DATA2} !== {1'b0, 32'h0, 1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL fwd_swap got h1=%b d1=%h h2=%b d2=%h want 0/0/1/deadbeef", FWD_HIT1, FWD_DATA1, FWD_HIT2, FWD_DATA2);
        end
        @(posedge CLK);
        #1;
    endtask
`endif

    initial begin
        @(posedge CLK);
        #1;
        test_reset();
        test_alu();
        test_md();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef WB_FWD_EN
        test_fwd();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
